// File: rtl/fetch_unit_pkg.sv
// Shared widths, fetch-entry layout and reset PC for the fetch stage.
package fetch_unit_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned INSTR_W    = 32;

    localparam logic [DEF_ADDR_W-1:0] RESET_PC = '0;

    // One queued instruction tagged with the word address it came from.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [INSTR_W-1:0]    instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous in-order FIFO; flush empties it and wins over push/pop.
// The caller must not push while full unless it pops in the same cycle.
module fetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 40
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          push_data,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // Storage, pointers and occupancy; storage is cleared on reset so the
    // head reads zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Head and full come straight from registered state.
    assign head = mem[rd_ptr];
    assign full = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, ROM addressing and a fetch queue drained
// by decode; a redirect flushes the queue and restarts fetch.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_en,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [INSTR_W-1:0]  rom_data,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]   out_pc
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]  pc;
    logic               push;
    logic               pop;
    logic               full;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;

    // A full queue still accepts a push when the head leaves this cycle.
    assign pop       = out_valid & out_ready;
    assign push      = fetch_en & ~redirect_valid & (~full | pop);
    assign out_valid = (count != '0);
    assign rom_addr  = pc;
    assign {out_pc, out_instr} = head;

    // Program counter: redirect first, otherwise advance on every push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (push) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    fetch_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data ({pc, rom_data}),
        .head      (head),
        .count     (count),
        .full      (full)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit with a queue-based reference model and a
// scoreboard monitor comparing the queue head every cycle.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;

    logic [31:0]  rom [256];
    fetch_entry_t exp_q [$];
    logic [7:0]   mpc;
    int           n_checks;
    int           n_fail;

    fetch_unit #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every sampled edge either redirects (flush, new PC)
    // or, if fetching is allowed and there is room after this cycle's pop,
    // appends {pc, rom[pc]} and moves to the next word address.
    always @(posedge clk) begin
        if (!rst) begin
            if (redirect_valid) begin
                exp_q.delete();
                mpc = redirect_pc;
            end else if (fetch_en && exp_q.size() < DEPTH) begin
                exp_q.push_back('{pc: mpc, instr: rom[mpc]});
                mpc = mpc + 8'd1;
            end
        end
    end

    // Monitor: compare visible state against the model away from the
    // active edge, then retire the head if decode takes it this cycle.
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("rom_addr", 32'(rom_addr), 32'(mpc));
        if (exp_q.size() != 0) begin
            chk("out_pc", 32'(out_pc), 32'(exp_q[0].pc));
            chk("out_instr", out_instr, exp_q[0].instr);
            if (out_ready && !redirect_valid && !rst) begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic fe, input logic rdy, input logic rv,
                         input logic [7:0] rpc, input int n);
        fetch_en       = fe;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_instr"}, out_instr, 32'd0);
        chk({tag, "_pc"}, 32'(out_pc), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mpc      = 8'd0;
        for (int i = 0; i < 256; i++) begin
            rom[i] = $urandom;
        end
        rom[0] = 32'h0000_0013;
        rom[1] = 32'h0010_0093;
        rom[2] = 32'h0020_0113;
        rom[6] = 32'h0000_0000;

        rst            = 1'b1;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b0;

        // Streaming, back-pressure to full, then drain with full+pop.
        drive(1'b1, 1'b1, 1'b0, 8'h00, 12);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 10);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 10);

        // Redirect while entries are queued; the discarded head is not retired.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 3);
        drive(1'b1, 1'b1, 1'b1, 8'h40, 1);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 5);

        // PC wrap from 0xFE.
        drive(1'b0, 1'b1, 1'b1, 8'hFE, 1);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 6);

        // Random traffic.
        repeat (400) begin
            fetch_en       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 8'($urandom);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a cycle with a non-empty queue.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 3);
        redirect_valid = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        mpc = 8'd0;
        #1;
        chk_zero_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'h00, 10);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage: holds the program counter, drives the word address of the instruction ROM and captures the combinational 32-bit instruction it returns. Fetched instructions, each tagged with its PC, go into a small in-order fetch queue. The decode stage drains the queue over a valid/ready handshake. A redirect port (branch resolution / flush from the out-of-order back end) discards queued instructions and restarts fetch at a new address.

## Interface

- DEPTH, 4: fetch queue entries; power of two, minimum 2.
- ADDR_W, 8: PC / ROM word-address width; addresses are word indices, not byte addresses.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  fetch allowed this cycle; when low, the PC holds and nothing is pushed.
- rom_addr  out  ADDR_W  word address to the ROM; always equal to the PC register.
- rom_data  in  32  instruction from the ROM, valid combinationally in the same cycle as rom_addr.
- redirect_valid  in  1  flush the queue and load redirect_pc.
- redirect_pc  in  ADDR_W  restart address.
- out_valid  out  1  the queue head holds an instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  ADDR_W  PC of the head instruction.

## Operation

- State: pc (ADDR_W), queue storage DEPTH x {pc, instr}, rd_ptr and wr_ptr (log2 DEPTH bits, wrap naturally), count (log2 DEPTH + 1 bits, range 0..DEPTH).
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop). A full queue with a simultaneous pop still pushes.
- On push: the entry at wr_ptr is loaded with {pc, rom_data}; wr_ptr increments; pc becomes pc+1 mod 2^ADDR_W, so 255 wraps to 0.
- On pop: rd_ptr increments.
- count next = count + push − pop. Push and pop together leave count unchanged.
- Redirect has priority over everything. On redirect: rd_ptr, wr_ptr and count go to 0; pc loads redirect_pc; no push that cycle; an out_ready in the same cycle is ignored because the head is discarded.
- out_valid = (count != 0). out_instr and out_pc come combinationally from the entry at rd_ptr.
- When the queue is empty, out_instr and out_pc are don't-care except straight after reset (see Timing).
- No instruction decoding happens here. An all-zero word is queued like any other.

## Timing

- Reset values: pc = 0, rom_addr = 0, count = 0, out_valid = 0, all queue storage = 0, so out_instr = 0 and out_pc = 0.
- Reset takes effect immediately (asynchronous). Deassertion is sampled synchronously; the first edge with rst low may push.
- Fetch-to-decode latency: one cycle. An instruction present on rom_data at edge N shows on out_instr with out_valid=1 after edge N.
- Throughput: one instruction per cycle while fetch_en=1 and out_ready=1.
- Redirect latency: redirect sampled at edge N gives out_valid=0 and rom_addr=redirect_pc after edge N. The first redirected instruction is valid after edge N+1.
- Back-pressure: with out_ready=0 and fetch_en=1, exactly DEPTH pushes occur, then the PC holds. No entry is overwritten or lost.
- rst asserted mid-operation discards the queue and returns pc to 0 with no partial update.
- out_valid is a function of registered state only. out_instr and out_pc have no combinational path from out_ready or from rom_data.

## Structure

- Shared package: ADDR_W default, instruction width (32), a fetch-entry typedef {pc, instr}, and the reset PC constant (0).
- One natural sub-module: fetch_queue. It is a parameterised synchronous FIFO with push, pop and flush inputs and count, head and full outputs. The PC, push logic and redirect priority stay in fetch_unit.

## Test plan

- Reset then fetch_en=1, out_ready=1, ROM preloaded with words 0x00000013, 0x00100093, ... -> out_pc = 0,1,2,... with the matching instr every cycle from the first post-reset edge.
- out_ready=0 for 10 cycles with DEPTH=4 -> exactly 4 entries queued, rom_addr holds at 4, out_pc stays 0. Then out_ready=1 -> PCs 0..7 delivered in order, none dropped or duplicated.
- Queue full plus pop in the same cycle -> count stays 4, rom_addr advances by 1.
- Queue holding PCs 5..7, redirect_valid with redirect_pc=0x40 and out_ready=1 -> next cycle out_valid=0 and rom_addr=0x40; the following cycle out_pc=0x40. PCs 5..7 are never delivered.
- PC at 0xFE, continuous fetch -> out_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- rst pulsed mid-cycle while the queue is non-empty -> out_valid, out_instr and out_pc drop to 0 immediately, and fetch resumes from 0 after release.
